// File: rtl/cic_interp_stage.sv
// cic_interp_stage: 4th-order CIC interpolator (rate 1..128) that paces its upstream stage via stb_req.
// Build option: define CIC_INTERP_ROUND_EN for round-half-up gain normalisation; truncation otherwise.
module cic_interp_stage #(
    parameter int WIDTH = 18,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       rate,
    output logic             stb_req,
    input  logic [WIDTH-1:0] data_in,
    output logic             stb_out,
    output logic [WIDTH-1:0] data_out
);
    localparam int IW = WIDTH + 21;
    localparam int SW = IW + 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

    logic [6:0]           rate_m1_c;
    logic [6:0]           rate_m1;
    logic [6:0]           cnt;
    logic [4:0]           shift_c;
    logic [4:0]           shift_s;
    logic                 run;
    logic                 cap_stb;
    logic                 cap_d;
    logic signed [IW-1:0] in_reg;
    logic signed [IW-1:0] zs;
    logic signed [IW-1:0] comb_out;
    logic signed [IW-1:0] comb_in [N];
    logic signed [IW-1:0] dly     [N];
    logic signed [IW-1:0] integ   [N];
    logic signed [SW-1:0] rnd_sum;
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] sh_r;
    logic [6:0]           en_pipe;

    always_comb begin
        if (rate == 8'd0)
            rate_m1_c = '0;
        else if (rate > 8'd128)
            rate_m1_c = '1;
        else
            rate_m1_c = 7'(rate - 8'd1);
    end

    // ceil(log2 R) equals the bit length of R-1
    always_comb begin
        shift_c = '0;
        for (int unsigned i = 0; i < 7; i++)
            if (rate_m1_c[i])
                shift_c = 5'(3 * (i + 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_m1 <= '0;
            shift_s <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            stb_req <= 1'b0;
        end else if (!enable) begin
            rate_m1 <= rate_m1_c;
            shift_s <= shift_c;
            cnt     <= rate_m1_c;
            run     <= 1'b0;
            stb_req <= 1'b0;
        end else begin
            run <= 1'b1;
            if (!run || cnt == '0) begin
                stb_req <= 1'b1;
                cnt     <= rate_m1;
            end else begin
                stb_req <= 1'b0;
                cnt     <= cnt - 7'd1;
            end
        end
    end

    always_comb begin
        logic signed [IW-1:0] acc;
        acc = in_reg;
        for (int unsigned k = 0; k < N; k++) begin
            comb_in[k] = acc;
            acc        = acc - dly[k];
        end
        comb_out = acc;
    end

    always_comb begin
        rnd_sum = {integ[N-1][IW-1], integ[N-1]};
`ifdef CIC_INTERP_ROUND_EN
        if (shift_s != '0)
            rnd_sum = rnd_sum + (SW'(1) << (shift_s - 5'd1));
`endif
        shifted = rnd_sum >>> shift_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_stb  <= 1'b0;
            cap_d    <= 1'b0;
            in_reg   <= '0;
            zs       <= '0;
            sh_r     <= '0;
            data_out <= '0;
            en_pipe  <= '0;
            stb_out  <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                dly[k]   <= '0;
                integ[k] <= '0;
            end
        end else if (!enable) begin
            cap_stb  <= 1'b0;
            cap_d    <= 1'b0;
            in_reg   <= '0;
            zs       <= '0;
            sh_r     <= '0;
            data_out <= '0;
            en_pipe  <= '0;
            stb_out  <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                dly[k]   <= '0;
                integ[k] <= '0;
            end
        end else begin
            cap_stb <= stb_req;
            cap_d   <= cap_stb;
            if (cap_stb) begin
                in_reg <= {{(IW - WIDTH){data_in[WIDTH-1]}}, data_in};
                for (int unsigned k = 0; k < N; k++)
                    dly[k] <= comb_in[k];
            end
            // zero-stuffing: the comb result enters the integrators once per input sample
            zs       <= cap_d ? comb_out : '0;
            integ[0] <= integ[0] + zs;
            for (int unsigned k = 1; k < N; k++)
                integ[k] <= integ[k] + integ[k-1];
            sh_r <= shifted;
            if (sh_r > SAT_HI)
                data_out <= SAT_HI[WIDTH-1:0];
            else if (sh_r < SAT_LO)
                data_out <= SAT_LO[WIDTH-1:0];
            else
                data_out <= sh_r[WIDTH-1:0];
            en_pipe <= {en_pipe[5:0], 1'b1};
            stb_out <= en_pipe[6];
        end
    end
endmodule
